vga_frame_checker: RTL and testbench

- Sink-side checker for the VGA timing/pixel stream our generator drives (hs, vs, de, 8-bit r/g/b), clocked in the same pixel clock domain.
- Recovers line and frame timing and measures totals and active sizes.
- Runs a lock state machine, computes a per-frame pixel checksum, and captures the pixel at a programmable probe coordinate.
- Used in the board self-test path and as the bench scoreboard front end for display-pipeline verification.

---
 rtl/vga_frame_checker.sv | 210 +++++++++++++++++++++
 tb/tb_vga_frame_checker.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_checker.sv
// Sink-side VGA timing checker: measures line/frame geometry, tracks lock, sums active
// pixels per frame and captures the pixel at a programmable probe coordinate.
module vga_frame_checker #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned TIMEOUT     = 4095
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_de,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic [11:0] probe_x,
  input  logic [11:0] probe_y,
  output logic [11:0] meas_h_total,
  output logic [11:0] meas_h_active,
  output logic [11:0] meas_v_total,
  output logic [11:0] meas_v_active,
  output logic [31:0] frame_checksum,
  output logic        frame_done,
  output logic        locked,
  output logic        lock_err,
  output logic [7:0]  err_count,
  output logic [23:0] probe_rgb,
  output logic        probe_hit
);

  typedef enum logic [1:0] {StSearch, StMeasure, StVerify, StLocked} state_e;

  localparam logic [11:0] TimeoutCnt = 12'(TIMEOUT);
  localparam logic [3:0]  LockCnt    = 4'(LOCK_FRAMES);

  state_e      state_q, state_d;
  logic [3:0]  match_q, match_d;
  logic        ref_load, lock_err_d;

  logic        prev_hs_q, prev_vs_q;
  logic [11:0] h_cnt_q, de_cnt_q, last_len_q, last_de_q, v_cnt_q, act_q, py_q;
  logic [31:0] sum_q;
  logic        hit_done_q;
  logic [11:0] ref_h_total_q, ref_h_active_q, ref_v_total_q, ref_v_active_q;
  logic [11:0] meas_h_total_q, meas_h_active_q, meas_v_total_q, meas_v_active_q;
  logic [31:0] checksum_q;
  logic        frame_done_q, lock_err_q, probe_hit_q;
  logic [7:0]  err_count_q;
  logic [23:0] probe_rgb_q;

  logic        hs_fall, vs_fall, line_act, frame_eq, line_bad, timeout, probe_match, frame_upd;
  logic [31:0] pix, fr_sum;
  logic [11:0] fr_h_total, fr_h_active, fr_v_total, fr_v_active;

  // A line ending on the vs_fall cycle still belongs to the frame being closed.
  assign hs_fall     = prev_hs_q & ~vga_hs;
  assign vs_fall     = prev_vs_q & ~vga_vs;
  assign line_act    = hs_fall & (de_cnt_q != 12'd0);
  assign pix         = {8'h00, vga_r, vga_g, vga_b};
  assign fr_h_total  = hs_fall ? h_cnt_q : last_len_q;
  assign fr_h_active = line_act ? de_cnt_q : last_de_q;
  assign fr_v_total  = v_cnt_q + {11'd0, hs_fall} - 12'd1;
  assign fr_v_active = act_q + {11'd0, line_act};
  assign fr_sum      = vga_de ? sum_q + pix : sum_q;
  assign frame_eq    = (fr_h_total == ref_h_total_q) && (fr_h_active == ref_h_active_q) &&
                       (fr_v_total == ref_v_total_q) && (fr_v_active == ref_v_active_q);
  assign line_bad    = hs_fall & (h_cnt_q != ref_h_total_q);
  assign timeout     = (h_cnt_q == TimeoutCnt);
  assign probe_match = vga_de & (de_cnt_q == probe_x) & (py_q == probe_y) & ~hit_done_q;
  assign frame_upd   = vs_fall & (state_q != StSearch);

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    ref_load   = 1'b0;
    lock_err_d = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (vs_fall) state_d = StMeasure;
      end
      StMeasure: begin
        if (timeout) begin
          state_d = StSearch;
        end else if (vs_fall) begin
          state_d  = StVerify;
          ref_load = 1'b1;
          match_d  = 4'd0;
        end
      end
      StVerify: begin
        if (timeout) begin
          state_d = StSearch;
        end else if (vs_fall) begin
          if (frame_eq) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 >= LockCnt) state_d = StLocked;
          end else begin
            ref_load = 1'b1;
            match_d  = 4'd0;
          end
        end
      end
      StLocked: begin
        if (timeout || line_bad || (vs_fall && !frame_eq)) begin
          state_d    = StSearch;
          lock_err_d = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StSearch;
      match_q <= 4'd0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_hs_q       <= 1'b1;
      prev_vs_q       <= 1'b1;
      h_cnt_q         <= '0;
      de_cnt_q        <= '0;
      last_len_q      <= '0;
      last_de_q       <= '0;
      v_cnt_q         <= '0;
      act_q           <= '0;
      py_q            <= '0;
      sum_q           <= '0;
      hit_done_q      <= 1'b0;
      ref_h_total_q   <= '0;
      ref_h_active_q  <= '0;
      ref_v_total_q   <= '0;
      ref_v_active_q  <= '0;
      meas_h_total_q  <= '0;
      meas_h_active_q <= '0;
      meas_v_total_q  <= '0;
      meas_v_active_q <= '0;
      checksum_q      <= '0;
      frame_done_q    <= 1'b0;
      lock_err_q      <= 1'b0;
      err_count_q     <= '0;
      probe_rgb_q     <= '0;
      probe_hit_q     <= 1'b0;
    end else begin
      prev_hs_q <= vga_hs;
      prev_vs_q <= vga_vs;
      if (hs_fall) begin
        h_cnt_q    <= '0;
        last_len_q <= h_cnt_q;
        de_cnt_q   <= '0;
        v_cnt_q    <= v_cnt_q + 12'd1;
        if (line_act) begin
          last_de_q <= de_cnt_q;
          act_q     <= act_q + 12'd1;
          py_q      <= py_q + 12'd1;
        end
      end else begin
        if (h_cnt_q != 12'hfff) h_cnt_q <= h_cnt_q + 12'd1;
        if (vga_de) de_cnt_q <= de_cnt_q + 12'd1;
      end
      sum_q       <= fr_sum;
      probe_hit_q <= probe_match;
      if (probe_match) begin
        probe_rgb_q <= pix[23:0];
        hit_done_q  <= 1'b1;
      end
      if (vs_fall) begin
        sum_q      <= '0;
        v_cnt_q    <= '0;
        act_q      <= '0;
        py_q       <= '0;
        hit_done_q <= 1'b0;
      end
      frame_done_q <= frame_upd;
      if (frame_upd) begin
        meas_h_total_q  <= fr_h_total;
        meas_h_active_q <= fr_h_active;
        meas_v_total_q  <= fr_v_total;
        meas_v_active_q <= fr_v_active;
        checksum_q      <= fr_sum;
      end
      if (ref_load) begin
        ref_h_total_q  <= fr_h_total;
        ref_h_active_q <= fr_h_active;
        ref_v_total_q  <= fr_v_total;
        ref_v_active_q <= fr_v_active;
      end
      lock_err_q <= lock_err_d;
      if (lock_err_d && (err_count_q != 8'hff)) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign meas_h_total   = meas_h_total_q;
  assign meas_h_active  = meas_h_active_q;
  assign meas_v_total   = meas_v_total_q;
  assign meas_v_active  = meas_v_active_q;
  assign frame_checksum = checksum_q;
  assign frame_done     = frame_done_q;
  assign locked         = (state_q == StLocked);
  assign lock_err       = lock_err_q;
  assign err_count      = err_count_q;
  assign probe_rgb      = probe_rgb_q;
  assign probe_hit      = probe_hit_q;

endmodule

// File: tb/tb_vga_frame_checker.sv
// Randomised bench for vga_frame_checker with a frame-level reference model.
module tb_vga_frame_checker;

  localparam int unsigned LockFrames = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vga_hs = 1'b1, vga_vs = 1'b1, vga_de = 1'b0;
  logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic [11:0] probe_x = '0, probe_y = '0;
  logic [11:0] meas_h_total, meas_h_active, meas_v_total, meas_v_active;
  logic [31:0] frame_checksum;
  logic        frame_done, locked, lock_err, probe_hit;
  logic [7:0]  err_count;
  logic [23:0] probe_rgb;

  vga_frame_checker #(.LOCK_FRAMES(LockFrames), .TIMEOUT(4095)) dut (
    .clk(clk), .reset_n(reset_n), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .probe_x(probe_x), .probe_y(probe_y),
    .meas_h_total(meas_h_total), .meas_h_active(meas_h_active), .meas_v_total(meas_v_total),
    .meas_v_active(meas_v_active), .frame_checksum(frame_checksum), .frame_done(frame_done),
    .locked(locked), .lock_err(lock_err), .err_count(err_count), .probe_rgb(probe_rgb),
    .probe_hit(probe_hit)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hit_seen = 0;
  int err_seen = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (probe_hit) hit_seen <= hit_seen + 1;
      if (lock_err)  err_seen <= err_seen + 1;
    end
  end

  // Reference model: 0 search, 1 measure, 2 verify, 3 locked.
  int m_state, m_match, m_errs;
  int ref_ht, ref_ha, ref_vt, ref_va;
  int e_ht, e_ha, e_vt, e_va;
  logic [31:0] e_sum;
  logic [23:0] m_probe;
  int f_ht, f_ha, f_vt, f_va, f_hits;
  logic [31:0] f_sum;
  int hit_base, err_base, errs_base;
  int n_lines, pix_mode;
  int len_a[32];
  int de_a[32];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic hs, input logic vs, input logic de, input logic [23:0] p);
    vga_hs = hs;
    vga_vs = vs;
    vga_de = de;
    {vga_r, vga_g, vga_b} = p;
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    hit_base  = hit_seen;
    err_base  = err_seen;
    errs_base = m_errs;
    f_hits    = 0;
  endtask

  task automatic model_reset();
    m_state = 0; m_match = 0; m_errs = 0;
    ref_ht = 0; ref_ha = 0; ref_vt = 0; ref_va = 0;
    e_ht = 0; e_ha = 0; e_vt = 0; e_va = 0; e_sum = '0; m_probe = '0;
    snap();
  endtask

  task automatic note_error();
    if (m_errs < 255) m_errs++;
  endtask

  task automatic line_end(input int k);
    if (m_state == 3 && len_a[k] - 1 != ref_ht) begin
      m_state = 0;
      note_error();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".h_total"}, 32'(meas_h_total), 32'd0);
    check({tag, ".h_active"}, 32'(meas_h_active), 32'd0);
    check({tag, ".v_total"}, 32'(meas_v_total), 32'd0);
    check({tag, ".v_active"}, 32'(meas_v_active), 32'd0);
    check({tag, ".cksum"}, frame_checksum, 32'd0);
    check({tag, ".done"}, 32'(frame_done), 32'd0);
    check({tag, ".locked"}, 32'(locked), 32'd0);
    check({tag, ".lock_err"}, 32'(lock_err), 32'd0);
    check({tag, ".err_count"}, 32'(err_count), 32'd0);
    check({tag, ".probe_rgb"}, 32'(probe_rgb), 32'd0);
    check({tag, ".probe_hit"}, 32'(probe_hit), 32'd0);
  endtask

  // Drives one frame except its first cycle, which edge_cycle supplies.
  task automatic body();
    int y, x;
    logic [23:0] p;
    logic de;
    snap();
    f_sum = '0;
    y = 0;
    for (int i = 0; i < n_lines; i++) begin
      for (int c = (i == 0) ? 1 : 0; c < len_a[i]; c++) begin
        if (c == 0) line_end(i - 1);
        x  = c - 6;
        de = (c >= 6) && (x < de_a[i]);
        case (pix_mode)
          0:       p = 24'($urandom);
          1:       p = {8'(x), 8'(y), 8'h5A};
          2:       p = 24'h010203;
          default: p = '0;
        endcase
        if (de) begin
          f_sum += {8'h00, p};
          if (x == int'(probe_x) && y == int'(probe_y) && f_hits == 0) begin
            f_hits++;
            m_probe = p;
          end
        end
        drive(c >= 4, i >= 2, de, p);
      end
      if (de_a[i] > 0) begin
        y++;
        f_ha = de_a[i];
      end
    end
    f_va = y;
    f_ht = len_a[n_lines - 1] - 1;
    f_vt = n_lines - 1;
  endtask

  task automatic edge_cycle(input string tag);
    bit done_exp, eq, last_bad;
    done_exp = (m_state != 0);
    last_bad = (m_state == 3) && (len_a[n_lines - 1] - 1 != ref_ht);
    eq = (f_ht == ref_ht) && (f_ha == ref_ha) && (f_vt == ref_vt) && (f_va == ref_va);
    case (m_state)
      0: m_state = 1;
      1: begin
        ref_ht = f_ht; ref_ha = f_ha; ref_vt = f_vt; ref_va = f_va;
        m_match = 0;
        m_state = 2;
      end
      2: begin
        if (eq) begin
          m_match++;
          if (m_match >= int'(LockFrames)) m_state = 3;
        end else begin
          ref_ht = f_ht; ref_ha = f_ha; ref_vt = f_vt; ref_va = f_va;
          m_match = 0;
        end
      end
      default: begin
        if (last_bad || !eq) begin
          m_state = 0;
          note_error();
        end
      end
    endcase
    if (done_exp) begin
      e_ht = f_ht; e_ha = f_ha; e_vt = f_vt; e_va = f_va; e_sum = f_sum;
    end
    drive(1'b0, 1'b0, 1'b0, 24'h0);
    @(negedge clk);
    #1;
    check({tag, ".done"}, 32'(frame_done), 32'(done_exp));
    check({tag, ".locked"}, 32'(locked), 32'(m_state == 3));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_errs));
    check({tag, ".err_pulses"}, 32'(err_seen - err_base), 32'(m_errs - errs_base));
    check({tag, ".h_total"}, 32'(meas_h_total), 32'(e_ht));
    check({tag, ".h_active"}, 32'(meas_h_active), 32'(e_ha));
    check({tag, ".v_total"}, 32'(meas_v_total), 32'(e_vt));
    check({tag, ".v_active"}, 32'(meas_v_active), 32'(e_va));
    check({tag, ".cksum"}, frame_checksum, e_sum);
    check({tag, ".probe_rgb"}, 32'(probe_rgb), 32'(m_probe));
    check({tag, ".probe_hits"}, 32'(hit_seen - hit_base), 32'(f_hits));
  endtask

  task automatic nominal();
    n_lines = 12;
    for (int i = 0; i < n_lines; i++) begin
      len_a[i] = 20;
      de_a[i]  = (i >= 2 && i < 8) ? 10 : 0;
    end
  endtask

  task automatic frame(input string tag);
    body();
    edge_cycle(tag);
  endtask

  initial begin
    int base_l, rep;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset_n = 1'b1;

    // Nominal geometry, constant colour; lock after the fourth vs_fall.
    nominal();
    pix_mode = 2;
    probe_x  = 12'd3;
    probe_y  = 12'd2;
    edge_cycle("f0");
    frame("f1");
    check("nom.h_total", 32'(meas_h_total), 32'd19);
    check("nom.h_active", 32'(meas_h_active), 32'd10);
    check("nom.v_total", 32'(meas_v_total), 32'd11);
    check("nom.v_active", 32'(meas_v_active), 32'd6);
    check("nom.cksum", frame_checksum, 32'h003C78B4);
    frame("f2");
    frame("f3");
    check("nom.locked", 32'(locked), 32'd1);

    pix_mode = 3;
    frame("zero");
    check("zero.cksum", frame_checksum, 32'd0);

    pix_mode = 1;
    frame("probe");
    check("probe.rgb", 32'(probe_rgb), 32'h0003025A);
    probe_y = 12'd6;
    frame("probe_miss");

    // One long line while locked, then relock.
    len_a[5] = 21;
    body();
    len_a[5] = 20;
    edge_cycle("long");
    check("long.err_count", 32'(err_count), 32'd1);
    check("long.locked", 32'(locked), 32'd0);
    for (int k = 0; k < 4; k++) frame("relock");
    check("relock.locked", 32'(locked), 32'd1);

    // hs stuck high while locked.
    body();
    if (m_state != 0) begin
      if (m_state == 3) note_error();
      m_state = 0;
    end
    repeat (5000) drive(1'b1, 1'b1, 1'b0, 24'h0);
    check("stuck.locked", 32'(locked), 32'd0);
    check("stuck.err_count", 32'(err_count), 32'd2);
    check("stuck.err_pulses", 32'(err_seen - err_base), 32'd1);
    edge_cycle("stuck_end");
    for (int k = 0; k < 3; k++) frame("post_stuck");

    // Reset in the middle of a frame.
    for (int c = 0; c < 25; c++) drive((c % 20) >= 4, 1'b1, 1'b0, 24'h0);
    reset_n = 1'b0;
    #1;
    check_zero("mid_reset");
    repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0);
    reset_n = 1'b1;
    model_reset();
    edge_cycle("post_reset");

    // Randomised geometry groups.
    for (int g = 0; g < 10; g++) begin
      base_l   = int'($urandom_range(14, 40));
      n_lines  = int'($urandom_range(6, 16));
      pix_mode = int'($urandom_range(0, 3));
      probe_x  = 12'($urandom_range(0, 12));
      probe_y  = 12'($urandom_range(0, 5));
      for (int i = 0; i < n_lines; i++)
        de_a[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, base_l - 7));
      de_a[2] = int'($urandom_range(1, base_l - 7));
      rep = int'($urandom_range(1, 5));
      for (int r = 0; r < rep; r++) begin
        for (int i = 0; i < n_lines; i++) len_a[i] = base_l;
        if ($urandom_range(0, 4) == 0) len_a[$urandom_range(1, n_lines - 2)] = base_l + 1;
        frame("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
